// File: rtl/insn_loader_if.sv
// Instruction-memory write port plus loader status, shared by insn_loader and its consumers.
interface insn_loader_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          busy;
    logic          done;
    logic          err;

    modport master (output we, wa, wd, busy, done, err);
    modport slave  (input  we, wa, wd, busy, done, err);
endinterface

// File: rtl/insn_loader.sv
// UART (8N1) program loader: parses {A5, N, N x {hi, lo}[, CSUM]} frames into instruction-memory writes.
// Optional trailing XOR checksum byte is enabled by defining INSN_LOADER_CSUM_EN.
module insn_loader #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int AW     = 8,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    insn_loader_if.master bus
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [7:0]    SYNC    = 8'hA5;

    // ---------------- RX front end ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t      r_state, r_next;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           rx_s1, rx_s2, rx_d;
    logic           byte_valid, frame_err;
    logic           bit_tick;

    assign bit_tick = (cnt == DIV_M1);

    always_comb begin
        r_next     = r_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (r_state)
            R_IDLE:  if (rx_d && !rx_s2) r_next = R_START;
            // mid-start re-check rejects glitches shorter than half a bit
            R_START: if (cnt == HALF_M1) r_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && bit_idx == 3'd7) r_next = R_STOP;
            R_STOP: begin
                if (bit_tick) begin
                    r_next     = R_IDLE;
                    byte_valid = rx_s2;
                    frame_err  = !rx_s2;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_d    <= rx_s2;
            r_state <= r_next;
            if (r_state == R_IDLE || r_next != r_state || (r_state == R_DATA && bit_tick))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (r_state == R_DATA && bit_tick) begin
                shreg   <= {rx_s2, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // ---------------- frame parser ----------------
    typedef enum logic [2:0] {
        P_IDLE, P_COUNT, P_HI, P_LO, P_WR, P_POST,
`ifdef INSN_LOADER_CSUM_EN
        P_CSUM,
`endif
        P_FINISH
    } p_state_t;

    p_state_t       p_state, p_next;
    logic [AW-1:0]  wa_q;
    logic [DW-1:0]  wd_q;
    logic [8:0]     rem;
    logic           err_q;
`ifdef INSN_LOADER_CSUM_EN
    logic [7:0]     csum;
`endif

    always_comb begin
        p_next = p_state;
        case (p_state)
            P_IDLE:  if (byte_valid && shreg == SYNC) p_next = P_COUNT;
            P_COUNT: if (byte_valid) p_next = P_HI;
            P_HI:    if (byte_valid) p_next = P_LO;
            P_LO:    if (byte_valid) p_next = P_WR;
            P_WR:    p_next = P_POST;
            P_POST: begin
`ifdef INSN_LOADER_CSUM_EN
                p_next = (rem == 9'd1) ? P_CSUM : P_HI;
`else
                p_next = (rem == 9'd1) ? P_FINISH : P_HI;
`endif
            end
`ifdef INSN_LOADER_CSUM_EN
            P_CSUM:  if (byte_valid) p_next = (shreg == csum) ? P_FINISH : P_IDLE;
`endif
            P_FINISH: p_next = P_IDLE;
            default:  p_next = P_IDLE;
        endcase
        // a broken stop bit abandons the frame wherever it is
        if (frame_err && p_state != P_IDLE) p_next = P_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state <= P_IDLE;
            wa_q    <= '0;
            wd_q    <= '0;
            rem     <= '0;
            err_q   <= 1'b0;
`ifdef INSN_LOADER_CSUM_EN
            csum    <= '0;
`endif
        end else begin
            p_state <= p_next;
            if (frame_err && p_state != P_IDLE) err_q <= 1'b1;
            case (p_state)
                P_IDLE: begin
                    if (byte_valid && shreg == SYNC) begin
                        err_q <= 1'b0;
`ifdef INSN_LOADER_CSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                P_COUNT: begin
                    if (byte_valid) begin
                        rem  <= (shreg == 8'd0) ? 9'd256 : {1'b0, shreg};
                        wa_q <= '0;
                    end
                end
                P_HI: begin
                    if (byte_valid) begin
                        wd_q[DW-1:DW-8] <= shreg;
`ifdef INSN_LOADER_CSUM_EN
                        csum <= csum ^ shreg;
`endif
                    end
                end
                P_LO: begin
                    if (byte_valid) begin
                        wd_q[7:0] <= shreg;
`ifdef INSN_LOADER_CSUM_EN
                        csum <= csum ^ shreg;
`endif
                    end
                end
                P_POST: begin
                    wa_q <= wa_q + 1'b1;
                    rem  <= rem - 1'b1;
                end
`ifdef INSN_LOADER_CSUM_EN
                P_CSUM: if (byte_valid && shreg != csum) err_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.we   = (p_state == P_WR);
    assign bus.wa   = wa_q;
    assign bus.wd   = wd_q;
    assign bus.busy = (p_state != P_IDLE) && (p_state != P_FINISH);
    assign bus.done = (p_state == P_FINISH);
    assign bus.err  = err_q;

endmodule

// File: tb/tb_insn_loader.sv
// Directed bench for insn_loader; runs with an 8-cycle bit period to keep the 256-word frame short.
module tb_insn_loader;

    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int checks = 0;
    int errors = 0;

    int            we_cnt   = 0;
    int            done_cnt = 0;
    logic [7:0]    wa_log[$];
    logic [15:0]   wd_log[$];

    insn_loader_if #(.AW(8), .DW(16)) bus ();

    insn_loader #(.CLK_HZ(8), .BAUD(1), .AW(8), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we) begin
            we_cnt++;
            wa_log.push_back(bus.wa);
            wd_log.push_back(bus.wd);
        end
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},   bus.we,   0);
        chk({tag, "_wa"},   bus.wa,   0);
        chk({tag, "_wd"},   bus.wd,   0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"},  bus.err,  0);
    endtask

    // sends {A5,02,12,34,AB,CD} then the given checksum byte when the feature is built in
    task automatic send_frame2(input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
`ifdef INSN_LOADER_CSUM_EN
        send_byte(cs, 1'b1);
`else
        if (cs == 8'hFF) $display("note: unexpected checksum arg");
`endif
    endtask

    task automatic chk_frame2(input string tag, input int base_we, input int base_done);
        chk({tag, "_wecnt"}, we_cnt - base_we, 2);
        chk({tag, "_wa0"},   wa_log[base_we],     8'h00);
        chk({tag, "_wd0"},   wd_log[base_we],     16'h1234);
        chk({tag, "_wa1"},   wa_log[base_we + 1], 8'h01);
        chk({tag, "_wd1"},   wd_log[base_we + 1], 16'hABCD);
        chk({tag, "_done"},  done_cnt - base_done, 1);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_err"},   bus.err,  0);
        chk({tag, "_wanext"}, bus.wa,  8'h02);
    endtask

    initial begin
        int bw, bd;

        // reset values while rst is held
        repeat (3) @(negedge clk);
        chk_idle_outputs("rst");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // reset halfway through a 0xA5 byte (start + 4 data bits)
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (DIV) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        chk_idle_outputs("midbyte");
        chk("midbyte_wecnt", we_cnt, 0);
        chk("midbyte_pstate", 32'(dut.p_state), 0);
        chk("midbyte_rstate", 32'(dut.r_state), 0);

        // reset mid-frame: SYNC accepted, then reset during N
        send_byte(8'hA5, 1'b1);
        chk("midframe_busy_pre", bus.busy, 1);
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        chk("midframe_busy", bus.busy, 0);
        chk("midframe_pstate", 32'(dut.p_state), 0);

        // basic two-word frame
        bw = we_cnt; bd = done_cnt;
        send_frame2(8'h40);
        chk_frame2("f2", bw, bd);

        // garbage before a frame is ignored
        bw = we_cnt; bd = done_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        chk("garb_wecnt", we_cnt - bw, 0);
        chk("garb_busy",  bus.busy, 0);
        chk("garb_done",  done_cnt - bd, 0);
        send_frame2(8'h40);
        chk_frame2("garb_f2", bw, bd);

        // framing error on the lo byte of word 1
        bw = we_cnt; bd = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        chk("ferr_wecnt", we_cnt - bw, 1);
        chk("ferr_wa0",   wa_log[bw], 8'h00);
        chk("ferr_wd0",   wd_log[bw], 16'h1234);
        chk("ferr_err",   bus.err,  1);
        chk("ferr_busy",  bus.busy, 0);
        chk("ferr_done",  done_cnt - bd, 0);
        // a stray byte after the error is ignored and err stays set
        send_byte(8'h12, 1'b1);
        chk("ferr_sticky", bus.err, 1);
        bw = we_cnt; bd = done_cnt;
        send_frame2(8'h40);
        chk_frame2("ferr_recover", bw, bd);

`ifdef INSN_LOADER_CSUM_EN
        // checksum mismatch: words stay written, err set, no done
        bw = we_cnt; bd = done_cnt;
        send_frame2(8'h41);
        chk("csum_wecnt", we_cnt - bw, 2);
        chk("csum_wd0",   wd_log[bw],     16'h1234);
        chk("csum_wd1",   wd_log[bw + 1], 16'hABCD);
        chk("csum_err",   bus.err,  1);
        chk("csum_busy",  bus.busy, 0);
        chk("csum_done",  done_cnt - bd, 0);
`endif

        // N=0 means 256 words; word i = {i, ~i}
        bw = we_cnt; bd = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1'b1);
            send_byte(~8'(i), 1'b1);
        end
`ifdef INSN_LOADER_CSUM_EN
        // each word XORs to FF; 256 of them cancel to 00
        send_byte(8'h00, 1'b1);
`endif
        chk("n256_wecnt", we_cnt - bw, 256);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("n256_wa%0d", i), wa_log[bw + i], 32'(i));
            chk($sformatf("n256_wd%0d", i), wd_log[bw + i], {16'h0, 8'(i), ~8'(i)});
        end
        chk("n256_wrap", bus.wa, 8'h00);
        chk("n256_done", done_cnt - bd, 1);
        chk("n256_busy", bus.busy, 0);
        chk("n256_err",  bus.err,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
